branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolves conditional branches dispatched from decode and returns the redirect to the PC controller.
- Drives `jump`, `jumppc` and `bneempty` toward the PC controller.
- Holds branches in a small reservation station and snoops the common data bus (CDB) for missing operands.
- Compares operands and issues a one-cycle redirect result.
- PC is word-addressed: sequential next PC is pc+1.

Parameters:
- DEPTH, 2, reservation-station entries (power of two, ≥2)
- TAG_W, 4, ROB/CDB tag width
- XLEN, 32, data and PC width

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dispValid  in  1  decode presents a branch this cycle
- dispReady  out  1  free entry exists; dispatch accepted when dispValid&dispReady
- dispPc  in  XLEN  word address of the branch
- dispSubType  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- dispImm  in  XLEN  sign-extended word offset
- dispRs1Ready / dispRs2Ready  in  1 each  operand value valid
- dispRs1Val / dispRs2Val  in  XLEN each  operand value
- dispRs1Tag / dispRs2Tag  in  TAG_W each  producer tag when not ready
- cdbValid  in  1  CDB broadcast valid
- cdbTag  in  TAG_W  broadcast tag
- cdbData  in  XLEN  broadcast value
- flush  in  1  synchronous pipeline flush
- jump  out  1  one-cycle pulse: branch resolved taken
- jumppc  out  XLEN  target, valid while jump=1
- resolveValid  out  1  one-cycle pulse on every resolution, taken or not
- bneempty  out  1  no occupied entry and no resolution in flight

Behaviour:
- Reset (async, rst_n=0):
  - all entries invalid
  - jump=0, resolveValid=0, jumppc=0
  - bneempty=1, dispReady=1
- Entry fields: valid, pc, subType, imm, and per operand {ready, val, tag}. Age is an allocation sequence counter of log2(DEPTH)+1 bits with wrap-safe compare.
- Dispatch:
  - written into the lowest-index free entry at the clock edge.
  - dispReady=0 when all entries are valid.
  - Same-cycle forwarding: if cdbValid matches a not-ready dispatched tag, the entry captures cdbData as ready.
- Snoop: each cycle, every valid entry with operand ready=0 and tag==cdbTag under cdbValid latches cdbData and sets ready=1.
- Select:
  - among entries with both operands ready, pick the oldest.
  - An operand captured from the CDB this cycle is not selectable until the next cycle.
- Compare (registered, latency 1 from select):
  - Selected entry is freed at the selecting edge.
  - Next cycle: resolveValid=1; jump=1 iff the condition holds.
  - Conditions: BEQ a==b; BNE a!=b; BLT/BGE signed; BLTU/BGEU unsigned.
  - jumppc = pc+imm, modulo 2^XLEN wrap. Undefined subType resolves not-taken.
- Throughput: at most one resolution per cycle; back-to-back resolutions are allowed.
- bneempty = no valid entry AND no resolution registered for the next cycle. It deasserts the edge after an accepted dispatch.
- flush:
  - all entries invalidated and the pending resolution cancelled.
  - jump/resolveValid=0 next cycle.
  - flush beats a simultaneous dispatch (dispatch dropped).
- Full with simultaneous select: dispReady reflects occupancy before the edge, so there is no same-cycle reuse of the freed slot.
- Reset mid-operation clears everything immediately; the outputs above hold until rst_n rises.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - adds outputs statTaken and statTotal (32-bit saturating counters).
  - They increment on each jump and resolveValid pulse respectively; reset to 0; flush does not clear them.
- Undefined: ports and counters absent; resolution timing identical.

Decomposition:
- Shared package holds:
  - branch funct3 constants (BR_BEQ..BR_BGEU)
  - the branch opcode constant 7'b1100011
  - the rs_entry struct typedef
  - the tag width default
- One natural sub-module: branch_compare (combinational funct3 evaluator returning taken), reused by any later branch unit.

Test Plan:
- BNE, pc=10, imm=5, rs1=3, rs2=4 all ready → cycle 2 after dispatch: jump=1, jumppc=15, resolveValid=1; bneempty=1 the following cycle.
- BEQ with rs1 tag=3 not ready; CDB tag 3 data 7 two cycles later; rs2=7 → no resolveValid before the capture; resolves jump=1 two cycles after the broadcast.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not-taken (resolveValid=1, jump=0).
- Fill DEPTH=2 entries with unready operands → dispReady=0, a third dispValid is ignored. Wake the younger first: it resolves first; the older resolves after its operand arrives.
- flush while 2 entries are valid and one selected → no jump/resolveValid afterward, bneempty=1 next cycle, dispReady=1.
- rst_n pulled low mid-resolution (asynchronous to clock) → jump=0, bneempty=1 immediately; resolution lost after release.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared constants and entry type for branch resolution
//
// Purpose: branch funct3 encodings, the branch opcode, default widths and the
//          reservation-station entry layout used by branch_resolve_unit.
// Ports:   none (package).
package branch_resolve_unit_pkg;

  localparam int BR_TAG_W = 4;
  localparam int BR_XLEN  = 32;

  localparam logic [6:0] BR_OPCODE = 7'b1100011;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Field widths follow the package defaults; the top checks its parameters
  // against them at elaboration.
  typedef struct packed {
    logic                valid;
    logic [BR_XLEN-1:0]  pc;
    logic [2:0]          sub_type;
    logic [BR_XLEN-1:0]  imm;
    logic                rs1_rdy;
    logic [BR_XLEN-1:0]  rs1_val;
    logic [BR_TAG_W-1:0] rs1_tag;
    logic                rs2_rdy;
    logic [BR_XLEN-1:0]  rs2_val;
    logic [BR_TAG_W-1:0] rs2_tag;
  } rs_entry_t;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// rtl/branch_resolve_unit_compare.sv - combinational funct3 branch condition evaluator
//
// Purpose: returns taken for a branch funct3 and two operands; unknown
//          encodings evaluate not-taken.
// Ports:   sub_type (funct3), a/b (operands), taken (condition holds).
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      sub_type,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (sub_type)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch reservation station with CDB snoop and registered resolve
//
// Purpose: holds dispatched conditional branches, wakes operands from the
//          CDB, selects the oldest ready entry and returns a registered
//          redirect (jump/jumppc) plus a resolve pulse one cycle later.
// Ports:   clock, rst_n (async active-low); disp* dispatch request with
//          dispReady back-pressure; cdb* result broadcast; flush;
//          jump/jumppc/resolveValid resolution; bneempty idle indicator.
//          statTaken/statTotal only when BRANCH_STATS_EN is defined.
// Macro:   BRANCH_STATS_EN - adds saturating taken/total resolution counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = BR_TAG_W,
  parameter int XLEN  = BR_XLEN
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             dispValid,
  output logic             dispReady,
  input  logic [XLEN-1:0]  dispPc,
  input  logic [2:0]       dispSubType,
  input  logic [XLEN-1:0]  dispImm,
  input  logic             dispRs1Ready,
  input  logic             dispRs2Ready,
  input  logic [XLEN-1:0]  dispRs1Val,
  input  logic [XLEN-1:0]  dispRs2Val,
  input  logic [TAG_W-1:0] dispRs1Tag,
  input  logic [TAG_W-1:0] dispRs2Tag,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [XLEN-1:0]  cdbData,
  input  logic             flush,
  output logic             jump,
  output logic [XLEN-1:0]  jumppc,
  output logic             resolveValid,
  output logic             bneempty
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      statTaken,
  output logic [31:0]      statTotal
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AGE_W = IDX_W + 1;

  if (XLEN != BR_XLEN || TAG_W != BR_TAG_W) begin : g_width_check
    $error("branch_resolve_unit: XLEN/TAG_W must match branch_resolve_unit_pkg widths");
  end

  rs_entry_t        rs_q   [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [AGE_W-1:0] alloc_age_q;
  logic             res_valid_q;
  logic             jump_q;
  logic [XLEN-1:0]  jumppc_q;

  // Ages differ by less than DEPTH, so the sign of the modular difference
  // orders them even after the counter wraps.
  function automatic logic is_older(input logic [AGE_W-1:0] x, input logic [AGE_W-1:0] y);
    logic [AGE_W-1:0] d;
    d = x - y;
    return d[AGE_W-1];
  endfunction

  logic [DEPTH-1:0] valid_vec;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;
  rs_entry_t        sel_entry;
  rs_entry_t        new_entry;
  logic             sel_taken;
  logic             disp_fire;

  always_comb begin
    valid_vec = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      valid_vec[i] = rs_q[i].valid;
      if (!rs_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Selection only sees registered ready bits, so an operand captured from
  // the CDB this cycle becomes selectable on the next one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs_q[i].valid && rs_q[i].rs1_rdy && rs_q[i].rs2_rdy &&
          (!sel_found || is_older(age_q[i], sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  assign sel_entry = rs_q[sel_idx];
  assign dispReady = ~&valid_vec;
  assign disp_fire = dispValid && dispReady && !flush;

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.pc       = dispPc;
    new_entry.sub_type = dispSubType;
    new_entry.imm      = dispImm;
    new_entry.rs1_tag  = dispRs1Tag;
    new_entry.rs2_tag  = dispRs2Tag;
    new_entry.rs1_rdy  = dispRs1Ready || (cdbValid && cdbTag == dispRs1Tag);
    new_entry.rs2_rdy  = dispRs2Ready || (cdbValid && cdbTag == dispRs2Tag);
    new_entry.rs1_val  = dispRs1Ready ? dispRs1Val : cdbData;
    new_entry.rs2_val  = dispRs2Ready ? dispRs2Val : cdbData;
  end

  branch_compare #(.XLEN(XLEN)) u_compare (
    .sub_type (sel_entry.sub_type),
    .a        (sel_entry.rs1_val),
    .b        (sel_entry.rs2_val),
    .taken    (sel_taken)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_q[i]  <= '0;
        age_q[i] <= '0;
      end
      alloc_age_q <= '0;
      res_valid_q <= 1'b0;
      jump_q      <= 1'b0;
      jumppc_q    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) rs_q[i].valid <= 1'b0;
      res_valid_q <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs_q[i].valid && !rs_q[i].rs1_rdy && cdbValid && cdbTag == rs_q[i].rs1_tag) begin
          rs_q[i].rs1_rdy <= 1'b1;
          rs_q[i].rs1_val <= cdbData;
        end
        if (rs_q[i].valid && !rs_q[i].rs2_rdy && cdbValid && cdbTag == rs_q[i].rs2_tag) begin
          rs_q[i].rs2_rdy <= 1'b1;
          rs_q[i].rs2_val <= cdbData;
        end
        if (sel_found && sel_idx == IDX_W'(i)) rs_q[i].valid <= 1'b0;
        // free_idx always names an empty slot, never the one being selected.
        if (disp_fire && free_idx == IDX_W'(i)) begin
          rs_q[i]  <= new_entry;
          age_q[i] <= alloc_age_q;
        end
      end
      if (disp_fire) alloc_age_q <= alloc_age_q + 1'b1;
      res_valid_q <= sel_found;
      jump_q      <= sel_found && sel_taken;
      if (sel_found) jumppc_q <= sel_entry.pc + sel_entry.imm;
    end
  end

  assign jump         = jump_q;
  assign jumppc       = jumppc_q;
  assign resolveValid = res_valid_q;
  assign bneempty     = ~|valid_vec && !res_valid_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      statTaken <= '0;
      statTotal <= '0;
    end else begin
      if (jump_q && statTaken != '1) statTaken <= statTaken + 32'd1;
      if (res_valid_q && statTotal != '1) statTotal <= statTotal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        dispValid;
  logic        dispReady;
  logic [31:0] dispPc;
  logic [2:0]  dispSubType;
  logic [31:0] dispImm;
  logic        dispRs1Ready, dispRs2Ready;
  logic [31:0] dispRs1Val, dispRs2Val;
  logic [3:0]  dispRs1Tag, dispRs2Tag;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        flush;
  logic        jump;
  logic [31:0] jumppc;
  logic        resolveValid;
  logic        bneempty;
`ifdef BRANCH_STATS_EN
  logic [31:0] statTaken, statTotal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  branch_resolve_unit dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .dispValid    (dispValid),
    .dispReady    (dispReady),
    .dispPc       (dispPc),
    .dispSubType  (dispSubType),
    .dispImm      (dispImm),
    .dispRs1Ready (dispRs1Ready),
    .dispRs2Ready (dispRs2Ready),
    .dispRs1Val   (dispRs1Val),
    .dispRs2Val   (dispRs2Val),
    .dispRs1Tag   (dispRs1Tag),
    .dispRs2Tag   (dispRs2Tag),
    .cdbValid     (cdbValid),
    .cdbTag       (cdbTag),
    .cdbData      (cdbData),
    .flush        (flush),
    .jump         (jump),
    .jumppc       (jumppc),
    .resolveValid (resolveValid),
    .bneempty     (bneempty)
`ifdef BRANCH_STATS_EN
    ,
    .statTaken    (statTaken),
    .statTotal    (statTotal)
`endif
  );

  typedef struct {
    logic [2:0]  sub;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_jump;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic dispatch(input logic [2:0] sub, input logic [31:0] pc, input logic [31:0] imm,
                          input logic r1_rdy, input logic [31:0] r1_val, input logic [3:0] r1_tag,
                          input logic r2_rdy, input logic [31:0] r2_val, input logic [3:0] r2_tag);
    dispValid    = 1'b1;
    dispSubType  = sub;
    dispPc       = pc;
    dispImm      = imm;
    dispRs1Ready = r1_rdy;
    dispRs1Val   = r1_val;
    dispRs1Tag   = r1_tag;
    dispRs2Ready = r2_rdy;
    dispRs2Val   = r2_val;
    dispRs2Tag   = r2_tag;
    @(posedge clock);
    @(negedge clock);
    dispValid = 1'b0;
  endtask

  task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] data);
    cdbValid = 1'b1;
    cdbTag   = tag;
    cdbData  = data;
    @(negedge clock);
    cdbValid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'b001, 32'd10,         32'd5,          32'd3,          32'd4,          1'b1, 32'd15};
    vecs[1] = '{3'b000, 32'd100,        32'hFFFF_FFFC,  32'd7,          32'd7,          1'b1, 32'd96};
    vecs[2] = '{3'b100, 32'd0,          32'd8,          32'hFFFF_FFFF,  32'd1,          1'b1, 32'd8};
    vecs[3] = '{3'b110, 32'd0,          32'd8,          32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0};
    vecs[4] = '{3'b101, 32'd50,         32'd3,          32'd5,          32'd5,          1'b1, 32'd53};
    vecs[5] = '{3'b111, 32'd50,         32'd3,          32'd1,          32'hFFFF_FFFF,  1'b0, 32'd0};
    vecs[6] = '{3'b010, 32'd50,         32'd3,          32'd5,          32'd5,          1'b0, 32'd0};
    vecs[7] = '{3'b000, 32'hFFFF_FFFE,  32'd3,          32'd0,          32'd0,          1'b1, 32'd1};
    vecs[8] = '{3'b101, 32'd50,         32'd3,          32'h8000_0000,  32'd0,          1'b0, 32'd0};

    rst_n = 1'b0;
    dispValid = 1'b0; dispPc = '0; dispSubType = '0; dispImm = '0;
    dispRs1Ready = 1'b0; dispRs2Ready = 1'b0; dispRs1Val = '0; dispRs2Val = '0;
    dispRs1Tag = '0; dispRs2Tag = '0;
    cdbValid = 1'b0; cdbTag = '0; cdbData = '0; flush = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_jump", {31'd0, jump}, 32'd0);
    check("rst_resolve", {31'd0, resolveValid}, 32'd0);
    check("rst_jumppc", jumppc, 32'd0);
    check("rst_bneempty", {31'd0, bneempty}, 32'd1);
    check("rst_dispready", {31'd0, dispReady}, 32'd1);
    rst_n = 1'b1;
    @(negedge clock);

    // Table: all operands ready, resolution two edges after dispatch.
    for (int i = 0; i < 9; i++) begin
      dispatch(vecs[i].sub, vecs[i].pc, vecs[i].imm, 1'b1, vecs[i].a, 4'd0, 1'b1, vecs[i].b, 4'd0);
      check($sformatf("v%0d_c1_bneempty", i), {31'd0, bneempty}, 32'd0);
      check($sformatf("v%0d_c1_resolve", i), {31'd0, resolveValid}, 32'd0);
      @(negedge clock);
      check($sformatf("v%0d_resolve", i), {31'd0, resolveValid}, 32'd1);
      check($sformatf("v%0d_jump", i), {31'd0, jump}, {31'd0, vecs[i].exp_jump});
      if (vecs[i].exp_jump) check($sformatf("v%0d_jumppc", i), jumppc, vecs[i].exp_pc);
      check($sformatf("v%0d_c2_bneempty", i), {31'd0, bneempty}, 32'd0);
      @(negedge clock);
      check($sformatf("v%0d_c3_bneempty", i), {31'd0, bneempty}, 32'd1);
      check($sformatf("v%0d_c3_resolve", i), {31'd0, resolveValid}, 32'd0);
    end

    // CDB wakeup: rs1 waits on tag 3, broadcast two cycles after dispatch.
    dispatch(3'b000, 32'd200, 32'd10, 1'b0, 32'd0, 4'd3, 1'b1, 32'd7, 4'd0);
    check("wk_c1_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    check("wk_c2_resolve", {31'd0, resolveValid}, 32'd0);
    cdb_pulse(4'd3, 32'd7);
    check("wk_c3_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    check("wk_resolve", {31'd0, resolveValid}, 32'd1);
    check("wk_jump", {31'd0, jump}, 32'd1);
    check("wk_jumppc", jumppc, 32'd210);
    @(negedge clock);

    // Fill both entries, reject a third, wake the younger first.
    dispatch(3'b000, 32'd20, 32'd1, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
    dispatch(3'b001, 32'd40, 32'd2, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);
    check("full_dispready", {31'd0, dispReady}, 32'd0);
    dispatch(3'b000, 32'd80, 32'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    check("full_third_resolve", {31'd0, resolveValid}, 32'd0);
    check("full_dispready2", {31'd0, dispReady}, 32'd0);
    cdb_pulse(4'd2, 32'd5);
    check("young_sel_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    check("young_resolve", {31'd0, resolveValid}, 32'd1);
    check("young_jump", {31'd0, jump}, 32'd1);
    check("young_jumppc", jumppc, 32'd42);
    check("young_dispready", {31'd0, dispReady}, 32'd1);
    cdb_pulse(4'd1, 32'd0);
    check("old_sel_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    check("old_resolve", {31'd0, resolveValid}, 32'd1);
    check("old_jump", {31'd0, jump}, 32'd1);
    check("old_jumppc", jumppc, 32'd21);
    @(negedge clock);
    check("fill_end_bneempty", {31'd0, bneempty}, 32'd1);
    check("fill_end_resolve", {31'd0, resolveValid}, 32'd0);

    // Flush with two valid entries, one being selected.
    dispatch(3'b000, 32'd300, 32'd1, 1'b0, 32'd0, 4'd4, 1'b1, 32'd0, 4'd0);
    dispatch(3'b000, 32'd60, 32'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    check("fl_pre_dispready", {31'd0, dispReady}, 32'd0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("fl_resolve", {31'd0, resolveValid}, 32'd0);
    check("fl_jump", {31'd0, jump}, 32'd0);
    check("fl_bneempty", {31'd0, bneempty}, 32'd1);
    check("fl_dispready", {31'd0, dispReady}, 32'd1);
    cdb_pulse(4'd4, 32'd0);
    check("fl_after_cdb_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    check("fl_late_resolve", {31'd0, resolveValid}, 32'd0);
    check("fl_late_bneempty", {31'd0, bneempty}, 32'd1);

    // Asynchronous reset while a taken resolution is on the outputs.
    dispatch(3'b000, 32'd400, 32'd4, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0);
    @(posedge clock);
    #1;
    check("ar_pre_jump", {31'd0, jump}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_jump", {31'd0, jump}, 32'd0);
    check("ar_bneempty", {31'd0, bneempty}, 32'd1);
    check("ar_resolve", {31'd0, resolveValid}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("ar_post_resolve", {31'd0, resolveValid}, 32'd0);
    check("ar_post_jump", {31'd0, jump}, 32'd0);
    check("ar_post_bneempty", {31'd0, bneempty}, 32'd1);
    check("ar_post_dispready", {31'd0, dispReady}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
